// File: rtl/core_inst_seq.sv
// Instruction sequencer for one attention tile: Q/K load, kernel preload, execute, drain, ofifo->pmem, SFP acc/div.
// Optional SEQ_PERF_CNT_EN adds a 32-bit busy-cycle counter output (cycle_cnt).
module core_inst_seq #(
  parameter int COL       = 8,
  parameter int Q_LEN     = 8,
  parameter int DRAIN_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_valid,
  output logic        data_req,
  output logic [18:0] inst,
  output logic        busy,
  output logic        done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE, QLOAD, KLOAD, KPRE, EXEC, DRAIN, OFIFO, ACC, DIV_RD, DIV_WR, DONE
  } state_e;

  localparam logic [4:0] Q_LAST     = 5'(Q_LEN - 1);
  localparam logic [4:0] Q_END      = 5'(Q_LEN);
  localparam logic [4:0] COL_LAST   = 5'(COL - 1);
  localparam logic [4:0] DRAIN_LAST = 5'(DRAIN_CYC - 1);

  state_e     state_q;
  logic [4:0] idx_q;
  logic [3:0] addr;

  assign addr = idx_q[3:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= QLOAD;
          idx_q   <= '0;
        end
        QLOAD: if (data_valid) begin
          if (idx_q == Q_LAST) begin state_q <= KLOAD; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        end
        KLOAD: if (data_valid) begin
          if (idx_q == COL_LAST) begin state_q <= KPRE; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        end
        KPRE:
          if (idx_q == COL_LAST) begin state_q <= EXEC; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        EXEC:
          if (idx_q == Q_LAST) begin state_q <= DRAIN; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        DRAIN:
          if (idx_q == DRAIN_LAST) begin state_q <= OFIFO; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        OFIFO:
          if (idx_q == Q_LAST) begin state_q <= ACC; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        ACC:
          if (idx_q == Q_END) begin state_q <= DIV_RD; idx_q <= '0; end
          else idx_q <= idx_q + 5'd1;
        DIV_RD: state_q <= DIV_WR;
        DIV_WR:
          if (idx_q == Q_LAST) begin state_q <= DONE; idx_q <= '0; end
          else begin state_q <= DIV_RD; idx_q <= idx_q + 5'd1; end
        DONE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    inst     = '0;
    data_req = 1'b0;
    unique case (state_q)
      QLOAD: begin
        data_req     = 1'b1;
        inst[15:12]  = addr;
        inst[4]      = data_valid;
      end
      KLOAD: begin
        data_req     = 1'b1;
        inst[15:12]  = addr;
        inst[2]      = data_valid;
      end
      KPRE: begin
        inst[15:12]  = addr;
        inst[6]      = 1'b1;
        inst[3]      = 1'b1;
      end
      EXEC: begin
        inst[15:12]  = addr;
        inst[7]      = 1'b1;
        inst[5]      = 1'b1;
      end
      OFIFO: begin
        inst[16]     = 1'b1;
        inst[11:8]   = addr;
        inst[0]      = 1'b1;
      end
      ACC: begin
        // Read of row k overlaps accumulation of row k-1.
        if (idx_q < Q_END) begin
          inst[1]    = 1'b1;
          inst[11:8] = addr;
        end
        if (idx_q != 5'd0) inst[17] = 1'b1;
      end
      DIV_RD: begin
        inst[1]      = 1'b1;
        inst[11:8]   = addr;
      end
      DIV_WR: begin
        inst[18]     = 1'b1;
        inst[0]      = 1'b1;
        inst[11:8]   = addr;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       cycle_cnt <= '0;
    else if (state_q == IDLE && start) cycle_cnt <= '0;
    else if (busy)                    cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule
